hf_lf_switch_ctrl: RTL
======================

HF_LF_SWITCH_CTRL -- requirements
Module: hf_lf_switch_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1024: consecutive stable cycles required to accept a new mode-pin level.
REQ-002 Parameter SETTLE_CYCLES, default 256: post-swap hold time with pads quiesced.
REQ-003 Parameter DRAIN_TIMEOUT, default 4096: maximum cycles spent waiting for the active core to go idle.
REQ-004 Parameter QUIESCE_CYCLES, default 4: pad-safe hold before the select flips.
REQ-005 pck0  in  1  sole clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 fpga_switch  in  1  asynchronous raw mode pin; 1=HF, 0=LF.
REQ-008 ncs  in  1  asynchronous SPI chip select, active-low; low means a transfer is in progress.
REQ-009 hf_busy, lf_busy  in  1 each  core activity flags (SSP frame in progress), pck0 domain.
REQ-010 err_clr  in  1  single-cycle clear of switch_err.
REQ-011 sel_hf  out  1  registered output-mux select; 1 routes the HF core.
REQ-012 quiesce  out  1  forces all pad drivers (pwr_*, ssp_*, adc_clk, dbg) to their safe low state.
REQ-013 hf_rst, lf_rst  out  1 each  hold the respective core in reset.
REQ-014 pwr_lo_en  out  1  LF low-power enable.
REQ-015 switching  out  1  high in every state except ACTIVE.
REQ-016 switch_err  out  1  sticky drain-timeout flag.
REQ-017 swap_count  out  8  completed-swap counter.

Function
REQ-018 fpga_switch and ncs SHALL each pass through a 2-flop synchronizer before any use.
REQ-019 Debounce: deb_mode SHALL update to the synchronized pin value only after DEBOUNCE_CYCLES consecutive equal samples; any change SHALL restart the count at 0.
REQ-020 FSM states SHALL be ACTIVE, DRAIN, QUIESCE, SWAP, SETTLE.
REQ-021 ACTIVE: quiesce=0; if deb_mode != sel_hf, next state SHALL be DRAIN.
REQ-022 DRAIN: if deb_mode returns to sel_hf, return to ACTIVE (abort, no swap).
REQ-023 DRAIN: when the selected core's busy flag=0 and synchronized ncs=1 in the same cycle, go to QUIESCE.
REQ-024 DRAIN: after DRAIN_TIMEOUT cycles without idle, go to QUIESCE and set switch_err.
REQ-025 Abort SHALL take priority over idle and timeout when they coincide.
REQ-026 QUIESCE: quiesce=1 for QUIESCE_CYCLES, then SWAP.
REQ-027 SWAP: one cycle; sel_hf SHALL toggle; swap_count SHALL increment, wrapping 255->0.
REQ-028 SETTLE: quiesce=1 for SETTLE_CYCLES, then ACTIVE; deb_mode changes SHALL be ignored until ACTIVE is reached and then re-evaluated.
REQ-029 hf_rst SHALL be 1 when sel_hf=0 or the state is QUIESCE/SWAP/SETTLE; lf_rst likewise with sel_hf=1.
REQ-030 pwr_lo_en SHALL be 1 only when in ACTIVE with sel_hf=0; it SHALL be 0 whenever HF is selected.
REQ-031 All outputs SHALL be registered; sel_hf toggles exactly one cycle after SWAP is entered.
REQ-032 switch_err SHALL clear on err_clr unless a timeout occurs in the same cycle (set wins).
REQ-033 Every state counter SHALL clear on each state entry; counter widths SHALL be sized by $clog2 of the largest parameter.

Reset
REQ-034 rst SHALL force state=SETTLE, counters=0, sel_hf=0, deb_mode=0, quiesce=1, hf_rst=1, lf_rst=1, pwr_lo_en=0, switching=1, switch_err=0, swap_count=0, and clear the synchronizers.
REQ-035 rst asserted mid-switch SHALL abandon the sequence with no partial swap.

Structure
REQ-036 The shared package hf_lf_pkg SHALL hold the state enumeration and the MODE_LF/MODE_HF constants.
REQ-037 The synchronizer-plus-debouncer SHALL be the sub-module mode_debounce, instanced once for fpga_switch; ncs uses a plain 2-flop synchronizer.

Verification (DEBOUNCE=8, SETTLE=16, TIMEOUT=32, QUIESCE=4)
REQ-038 Reset, pin=0 -> quiesce=1 for 16 cycles, then ACTIVE, sel_hf=0, pwr_lo_en=1, lf_rst=0.
REQ-039 Pin 0->1 held, cores idle -> DRAIN, QUIESCE 4 cycles, sel_hf=1, swap_count=1, SETTLE 16 cycles, then pwr_lo_en=0, hf_rst=0.
REQ-040 Pin 5-cycle glitch -> no state change, swap_count unchanged.
REQ-041 lf_busy held high, pin->1 -> switch_err=1 after 32 DRAIN cycles, swap completes; err_clr pulse -> switch_err=0.
REQ-042 Pin->1, then back to 0 while ncs=0 in DRAIN -> returns to ACTIVE, sel_hf=0, swap_count unchanged.
REQ-043 rst asserted during SETTLE after a swap -> all outputs at reset values the next cycle, sel_hf=0.

Source files
------------

// File: rtl/hf_lf_pkg.sv
// rtl/hf_lf_pkg.sv - shared state encoding and mode constants for the HF/LF switch controller
package hf_lf_pkg;

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_QUIESCE = 3'd2,
        ST_SWAP    = 3'd3,
        ST_SETTLE  = 3'd4
    } state_t;

    localparam logic MODE_LF = 1'b0;
    localparam logic MODE_HF = 1'b1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/mode_debounce.sv
// rtl/mode_debounce.sv - 2-flop synchronizer plus consecutive-sample debouncer for the mode pin
module mode_debounce #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int CNT_W           = 12
) (
    input  logic pck0,
    input  logic rst,
    input  logic pin_async,
    output logic deb_mode
);

    logic             sync1_q, sync2_q;
    logic             deb_mode_q, deb_mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The pin is binary, so any sample equal to deb_mode is a change that restarts the run.
    always_comb begin
        cnt_d      = '0;
        deb_mode_d = deb_mode_q;
        if (sync2_q != deb_mode_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_mode_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge pck0) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            cnt_q      <= '0;
            deb_mode_q <= 1'b0;
        end else begin
            sync1_q    <= pin_async;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            deb_mode_q <= deb_mode_d;
        end
    end

    assign deb_mode = deb_mode_q;

endmodule

// File: rtl/hf_lf_switch_ctrl.sv
// rtl/hf_lf_switch_ctrl.sv - sequences a glitch-free swap of the output mux between the HF and LF cores
module hf_lf_switch_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int SETTLE_CYCLES   = 256,
    parameter int DRAIN_TIMEOUT   = 4096,
    parameter int QUIESCE_CYCLES  = 4
) (
    input  logic       pck0,
    input  logic       rst,
    input  logic       fpga_switch,
    input  logic       ncs,
    input  logic       hf_busy,
    input  logic       lf_busy,
    input  logic       err_clr,
    output logic       sel_hf,
    output logic       quiesce,
    output logic       hf_rst,
    output logic       lf_rst,
    output logic       pwr_lo_en,
    output logic       switching,
    output logic       switch_err,
    output logic [7:0] swap_count
);
    import hf_lf_pkg::*;

    localparam int MAX_P = max4(DEBOUNCE_CYCLES, SETTLE_CYCLES, DRAIN_TIMEOUT, QUIESCE_CYCLES);
    localparam int CNT_W = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    logic             deb_mode;
    logic             ncs_s1_q, ncs_s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_hf_q, sel_hf_d;
    logic [7:0]       swap_count_q, swap_count_d;
    logic             switch_err_q, switch_err_d;
    logic             quiesce_q, quiesce_d;
    logic             hf_rst_q, hf_rst_d;
    logic             lf_rst_q, lf_rst_d;
    logic             pwr_lo_en_q, pwr_lo_en_d;
    logic             switching_q, switching_d;
    logic             sel_busy, timeout, quiet;

    mode_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_mode_debounce (
        .pck0     (pck0),
        .rst      (rst),
        .pin_async(fpga_switch),
        .deb_mode (deb_mode)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        timeout  = 1'b0;
        sel_busy = sel_hf_q ? hf_busy : lf_busy;
        case (state_q)
            ST_ACTIVE: begin
                cnt_d = '0;
                if (deb_mode != sel_hf_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Abort outranks idle, which outranks the timeout.
                if (deb_mode == sel_hf_q) begin
                    state_d = ST_ACTIVE;
                end else if (!sel_busy && ncs_s2_q) begin
                    state_d = ST_QUIESCE;
                end else if (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d = ST_QUIESCE;
                    timeout = 1'b1;
                end
            end
            ST_QUIESCE: if (cnt_q == CNT_W'(QUIESCE_CYCLES - 1)) state_d = ST_SWAP;
            ST_SWAP:    state_d = ST_SETTLE;
            ST_SETTLE:  if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_ACTIVE;
            default:    state_d = ST_SETTLE;
        endcase
        if (state_d != state_q) cnt_d = '0;

        sel_hf_d     = sel_hf_q ^ (state_q == ST_SWAP);
        swap_count_d = swap_count_q + {7'd0, state_q == ST_SWAP};

        switch_err_d = switch_err_q;
        if (timeout)      switch_err_d = 1'b1;
        else if (err_clr) switch_err_d = 1'b0;

        // Outputs are decoded from the next state so the registered copies line up with state_q.
        quiet       = (state_d == ST_QUIESCE) || (state_d == ST_SWAP) || (state_d == ST_SETTLE);
        quiesce_d   = quiet;
        hf_rst_d    = (sel_hf_d == MODE_LF) || quiet;
        lf_rst_d    = (sel_hf_d == MODE_HF) || quiet;
        pwr_lo_en_d = (state_d == ST_ACTIVE) && (sel_hf_d == MODE_LF);
        switching_d = (state_d != ST_ACTIVE);
    end

    always_ff @(posedge pck0) begin
        if (rst) begin
            ncs_s1_q     <= 1'b0;
            ncs_s2_q     <= 1'b0;
            state_q      <= ST_SETTLE;
            cnt_q        <= '0;
            sel_hf_q     <= MODE_LF;
            swap_count_q <= 8'd0;
            switch_err_q <= 1'b0;
            quiesce_q    <= 1'b1;
            hf_rst_q     <= 1'b1;
            lf_rst_q     <= 1'b1;
            pwr_lo_en_q  <= 1'b0;
            switching_q  <= 1'b1;
        end else begin
            ncs_s1_q     <= ncs;
            ncs_s2_q     <= ncs_s1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_hf_q     <= sel_hf_d;
            swap_count_q <= swap_count_d;
            switch_err_q <= switch_err_d;
            quiesce_q    <= quiesce_d;
            hf_rst_q     <= hf_rst_d;
            lf_rst_q     <= lf_rst_d;
            pwr_lo_en_q  <= pwr_lo_en_d;
            switching_q  <= switching_d;
        end
    end

    assign sel_hf     = sel_hf_q;
    assign quiesce    = quiesce_q;
    assign hf_rst     = hf_rst_q;
    assign lf_rst     = lf_rst_q;
    assign pwr_lo_en  = pwr_lo_en_q;
    assign switching  = switching_q;
    assign switch_err = switch_err_q;
    assign swap_count = swap_count_q;

endmodule
